// File: rtl/injector_arbiter.sv
// Arbitrates NUM_SRC tx/credit flit sources onto the single Task Injector input,
// locking the grant for a whole packet. Also aggregates end-of-applications flags.
module injector_arbiter #(
  parameter int FLIT_SIZE = 32,
  parameter int NUM_SRC   = 2,
  parameter int PRIO_SRC0 = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_SRC-1:0]             tx_i,
  input  logic [NUM_SRC*FLIT_SIZE-1:0]   data_i,
  input  logic [NUM_SRC-1:0]             eop_i,
  input  logic [NUM_SRC-1:0]             eoa_i,
  output logic [NUM_SRC-1:0]             credit_o,
  output logic                           tx_o,
  output logic [FLIT_SIZE-1:0]           data_o,
  input  logic                           credit_i,
  output logic [NUM_SRC-1:0]             grant_o,
  output logic                           eoa_o,
  output logic [15:0]                    pkt_cnt_o
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  // Handshake: a flit moves in any cycle where tx_o && credit_i; the granted
  // source sees that as credit_o[g] high while its tx_i[g] is high.
  state_e               state_q;
  logic [NUM_SRC-1:0]   grant_q;
  logic [PW-1:0]        gidx_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [15:0]          pkt_cnt_q;

  logic [PW-1:0]        win_idx;
  logic                 found;
  int                   cand;
  logic                 locked;
  logic                 sel_tx;
  logic                 sel_eop;
  logic [FLIT_SIZE-1:0] sel_data;
  logic                 last_xfer;

  // Round-robin search upward from rr_ptr; source 0 overrides when prioritised.
  always_comb begin
    win_idx = rr_ptr_q;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!found && tx_i[cand]) begin
        found   = 1'b1;
        win_idx = PW'(cand);
      end
    end
    if (PRIO_SRC0 != 0 && tx_i[0]) win_idx = '0;
  end

  assign locked    = (state_q == LOCKED);
  assign sel_tx    = tx_i[gidx_q];
  assign sel_eop   = eop_i[gidx_q];
  assign sel_data  = data_i[int'(gidx_q)*FLIT_SIZE +: FLIT_SIZE];

  assign tx_o      = locked && sel_tx;
  assign data_o    = (locked && sel_tx) ? sel_data : '0;
  assign credit_o  = locked ? (grant_q & {NUM_SRC{credit_i}}) : '0;
  assign last_xfer = tx_o && credit_i && sel_eop;

  assign grant_o   = grant_q;
  assign pkt_cnt_o = pkt_cnt_q;
  assign eoa_o     = (&eoa_i) && !locked && (tx_i == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|tx_i) begin
            grant_q <= NUM_SRC'(1) << win_idx;
            gidx_q  <= win_idx;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          // Grant is held until the eop flit moves, even if the source stalls.
          if (last_xfer) begin
            if (pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
            rr_ptr_q <= (gidx_q == PW'(NUM_SRC-1)) ? '0 : gidx_q + 1'b1;
            grant_q  <= '0;
            state_q  <= IDLE;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_injector_arbiter.sv
// Directed scoreboard bench: instance A (2 sources, source 0 prioritised) and
// instance B (3 sources, pure round-robin) share clock and reset.
module tb_injector_arbiter;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  s_tx  [2];
  logic [2:0]  s_eop [2];
  logic [31:0] s_data[2][3];
  logic [1:0]  a_eoa;
  logic        a_credit;
  logic        b_credit;

  logic [1:0]  a_credit_o, a_grant;
  logic        a_tx_o, a_eoa_o;
  logic [31:0] a_data_o;
  logic [15:0] a_pkt;

  logic [2:0]  b_credit_o, b_grant;
  logic        b_tx_o, b_eoa_o;
  logic [31:0] b_data_o;
  logic [15:0] b_pkt;

  injector_arbiter #(.FLIT_SIZE(32), .NUM_SRC(2), .PRIO_SRC0(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_i(s_tx[0][1:0]), .data_i({s_data[0][1], s_data[0][0]}),
    .eop_i(s_eop[0][1:0]), .eoa_i(a_eoa),
    .credit_o(a_credit_o), .tx_o(a_tx_o), .data_o(a_data_o), .credit_i(a_credit),
    .grant_o(a_grant), .eoa_o(a_eoa_o), .pkt_cnt_o(a_pkt)
  );

  injector_arbiter #(.FLIT_SIZE(32), .NUM_SRC(3), .PRIO_SRC0(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .tx_i(s_tx[1]), .data_i({s_data[1][2], s_data[1][1], s_data[1][0]}),
    .eop_i(s_eop[1]), .eoa_i(3'b000),
    .credit_o(b_credit_o), .tx_o(b_tx_o), .data_o(b_data_o), .credit_i(b_credit),
    .grant_o(b_grant), .eoa_o(b_eoa_o), .pkt_cnt_o(b_pkt)
  );

  int total = 0;
  int bad   = 0;

  // Expected entry: {expected one-hot grant (4b), flit (32b)}
  logic [35:0] exp_a[$];
  logic [35:0] exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dval(input int inst, input int s, input int p);
    return 32'hD000_0000 | (32'(inst) << 12) | (32'(s) << 8) | (32'(p) << 4);
  endfunction

  function automatic logic cr(input int inst, input int s);
    return (inst == 0) ? a_credit_o[s] : b_credit_o[s];
  endfunction

  task automatic push(input int inst, input int s, input int n, input logic [31:0] base);
    for (int f = 0; f < n; f++) begin
      if (inst == 0) exp_a.push_back({4'(1 << s), base + 32'(f)});
      else           exp_b.push_back({4'(1 << s), base + 32'(f)});
    end
  endtask

  // Source driver: present each flit until the arbiter returns credit for it.
  task automatic send(input int inst, input int s, input int n, input logic [31:0] base);
    int t;
    for (int f = 0; f < n; f++) begin
      s_tx[inst][s]   = 1'b1;
      s_data[inst][s] = base + 32'(f);
      s_eop[inst][s]  = (f == n-1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!cr(inst, s) && t < 200);
      check("src_credit", 64'(cr(inst, s)), 64'd1);
      @(posedge clk); #1;
    end
    s_tx[inst][s]   = 1'b0;
    s_eop[inst][s]  = 1'b0;
    s_data[inst][s] = '0;
  endtask

  task automatic sync();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && a_tx_o && a_credit) begin
      if (exp_a.size() == 0) check("a_unexpected_flit", 64'(a_data_o), 64'hFFFF_FFFF_FFFF);
      else begin
        check("a_flit", 64'({2'b00, a_grant, a_data_o}), 64'(exp_a.pop_front()));
        check("a_credit_o", 64'(a_credit_o), 64'(a_grant));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_tx_o && b_credit) begin
      if (exp_b.size() == 0) check("b_unexpected_flit", 64'(b_data_o), 64'hFFFF_FFFF_FFFF);
      else begin
        check("b_flit", 64'({1'b0, b_grant, b_data_o}), 64'(exp_b.pop_front()));
        check("b_credit_o", 64'(b_credit_o), 64'(b_grant));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int   pidx[5] = '{0, 1, 1, 1, 2};

  initial begin
    logic [31:0] base;
    int t;
    for (int i = 0; i < 2; i++) begin
      s_tx[i] = '0; s_eop[i] = '0;
      for (int s = 0; s < 3; s++) s_data[i][s] = '0;
    end
    a_eoa = 2'b00; a_credit = 1'b1; b_credit = 1'b1;
    rst_n = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_grant", 64'(a_grant), 64'd0);
    check("rst_tx", 64'(a_tx_o), 64'd0);
    check("rst_data", 64'(a_data_o), 64'd0);
    check("rst_credit", 64'(a_credit_o), 64'd0);
    check("rst_pkt", 64'(a_pkt), 64'd0);
    check("rst_eoa0", 64'(a_eoa_o), 64'd0);
    a_eoa = 2'b11; #1;
    check("rst_eoa1", 64'(a_eoa_o), 64'd1);
    a_eoa = 2'b00;
    @(posedge clk); #2 rst_n = 1'b1;

    // Single source, 4 flits, credit always high
    sync();
    base = dval(0, 1, 0);
    push(0, 1, 4, base);
    fork
      send(0, 1, 4, base);
      begin
        @(negedge clk); check("t1_grant_idle", 64'(a_grant), 64'd0);
        @(negedge clk); check("t1_grant", 64'(a_grant), 64'b10);
      end
    join
    @(negedge clk);
    check("t1_idle_grant", 64'(a_grant), 64'd0);
    check("t1_idle_tx", 64'(a_tx_o), 64'd0);
    check("t1_pkt", 64'(a_pkt), 64'd1);

    // Priority: both request together, source 0 wins
    sync();
    push(0, 0, 2, dval(0, 0, 1));
    push(0, 1, 2, dval(0, 1, 1));
    fork
      begin
        send(0, 0, 2, dval(0, 0, 1));
        @(negedge clk); check("t2_bubble", 64'(a_grant), 64'd0);
        @(negedge clk); check("t2_src1_grant", 64'(a_grant), 64'b10);
      end
      send(0, 1, 2, dval(0, 1, 1));
      begin
        @(negedge clk); @(negedge clk);
        check("t2_src0_first", 64'(a_grant), 64'b01);
      end
    join
    @(negedge clk);
    check("t2_pkt", 64'(a_pkt), 64'd3);

    // Backpressure: credit 1,0,0,1,1 across a 3-flit packet
    sync();
    a_credit = 1'b0;
    base = dval(0, 1, 2);
    push(0, 1, 3, base);
    fork
      send(0, 1, 3, base);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (a_grant == 2'b00 && t < 20);
        check("t3_grant", 64'(a_grant), 64'b10);
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          a_credit = pat[i];
          @(negedge clk);
          check("t3_credit_mirror", 64'(a_credit_o), pat[i] ? 64'b10 : 64'd0);
          check("t3_data_hold", 64'(a_data_o), 64'(base + 32'(pidx[i])));
        end
        @(posedge clk); #1;
        a_credit = 1'b1;
      end
    join
    @(negedge clk);
    check("t3_pkt", 64'(a_pkt), 64'd4);

    // EOA raised while source 1 is mid-packet
    sync();
    a_eoa = 2'b11;
    push(0, 1, 3, dval(0, 1, 3));
    fork
      send(0, 1, 3, dval(0, 1, 3));
      begin
        @(negedge clk); check("t4_eoa_req", 64'(a_eoa_o), 64'd0);
        @(negedge clk); check("t4_eoa_locked", 64'(a_eoa_o), 64'd0);
      end
    join
    @(negedge clk);
    check("t4_eoa_after", 64'(a_eoa_o), 64'd1);
    check("t4_pkt", 64'(a_pkt), 64'd5);
    a_eoa = 2'b01; #1;
    check("t4_eoa_partial", 64'(a_eoa_o), 64'd0);
    a_eoa = 2'b00;

    // Reset pulsed during flit 2 of 5
    sync();
    base = dval(0, 1, 4);
    push(0, 1, 1, base);
    s_tx[0][1] = 1'b1; s_data[0][1] = base; s_eop[0][1] = 1'b0;
    @(negedge clk); check("t5_grant_idle", 64'(a_grant), 64'd0);
    @(negedge clk); check("t5_grant", 64'(a_grant), 64'b10);
    @(posedge clk); #1;
    s_data[0][1] = base + 32'd1;
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_grant", 64'(a_grant), 64'd0);
    check("t5_rst_tx", 64'(a_tx_o), 64'd0);
    check("t5_rst_credit", 64'(a_credit_o), 64'd0);
    check("t5_rst_pkt", 64'(a_pkt), 64'd0);
    s_tx[0][1] = 1'b0; s_data[0][1] = '0;
    @(negedge clk); rst_n = 1'b1;
    sync();
    push(0, 0, 2, dval(0, 0, 5));
    send(0, 0, 2, dval(0, 0, 5));
    @(negedge clk);
    check("t5_resume_pkt", 64'(a_pkt), 64'd1);
    check("t5_resume_grant", 64'(a_grant), 64'd0);

    // Round-robin on 3 sources: expected grant order 0,1,2,0
    sync();
    push(1, 0, 2, dval(1, 0, 0));
    push(1, 1, 2, dval(1, 1, 0));
    push(1, 2, 2, dval(1, 2, 0));
    push(1, 0, 2, dval(1, 0, 1));
    fork
      begin
        send(1, 0, 2, dval(1, 0, 0));
        send(1, 0, 2, dval(1, 0, 1));
      end
      send(1, 1, 2, dval(1, 1, 0));
      send(1, 2, 2, dval(1, 2, 0));
    join
    @(negedge clk);
    check("t6_pkt", 64'(b_pkt), 64'd4);
    check("t6_idle", 64'(b_grant), 64'd0);

    check("a_queue_empty", 64'(exp_a.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
